// File: rtl/lvds_bitslip_ctrl.sv
// lvds_bitslip_ctrl: word-alignment controller for one LVDS deserializer lane.
// It runs in the divided (parallel-word) clock domain. It compares each
// deserialized word against a training pattern. While the lane is misaligned it
// issues single bitslip pulses, each followed by a settle interval. It reports
// lock after a run of consecutive matches, and an error if too many slips
// happen without reaching lock.
module lvds_bitslip_ctrl #(
    parameter int                    DATA_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'h3E0,
    parameter int                    MATCH_COUNT   = 16,
    parameter int                    SLIP_WAIT     = 4,
    parameter int                    MAX_SLIPS     = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  bitslip,
    output logic                  busy,
    output logic                  locked,
    output logic                  align_err,
    output logic [7:0]            slip_cnt
);

    // Terminal counter values. Each counter stops at the last value below
    // instead of running past it.
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(SLIP_WAIT - 1);
    localparam logic [7:0] SLIP_LIMIT = 8'(MAX_SLIPS);
    localparam logic [7:0] SLIP_SAT   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } state_t;

    state_t     state;
    logic [7:0] match_cnt;
    logic [7:0] wait_cnt;

    // Training FSM. All outputs are registered alongside the state, so each
    // status flag changes on the same edge as its state transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bitslip   <= 1'b0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            align_err <= 1'b0;
            slip_cnt  <= 8'd0;
            match_cnt <= 8'd0;
            wait_cnt  <= 8'd0;
        end else begin
            // bitslip is a single-cycle strobe. It is raised only on entry to SLIP.
            bitslip <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CHECK;
                        busy      <= 1'b1;
                        slip_cnt  <= 8'd0;
                        match_cnt <= 8'd0;
                        wait_cnt  <= 8'd0;
                    end
                end

                CHECK: begin
                    if (data_in == TRAIN_PATTERN) begin
                        match_cnt <= match_cnt + 8'd1;
                        if (match_cnt == MATCH_LAST) begin
                            state  <= LOCKED;
                            busy   <= 1'b0;
                            locked <= 1'b1;
                        end
                    end else begin
                        // Any mismatch restarts the run of consecutive matches.
                        match_cnt <= 8'd0;
                        if (slip_cnt == SLIP_LIMIT) begin
                            state     <= FAIL;
                            busy      <= 1'b0;
                            align_err <= 1'b1;
                        end else begin
                            state   <= SLIP;
                            bitslip <= 1'b1;
                        end
                    end
                end

                SLIP: begin
                    if (slip_cnt != SLIP_SAT) begin
                        slip_cnt <= slip_cnt + 8'd1;
                    end
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end

                WAIT: begin
                    // The deserializer output is unsettled here, so data_in is not sampled.
                    if (wait_cnt == WAIT_LAST) begin
                        state     <= CHECK;
                        match_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                LOCKED: begin
                    // Lock is not monitored. Only a new start leaves this state.
                    if (start) begin
                        state     <= CHECK;
                        locked    <= 1'b0;
                        busy      <= 1'b1;
                        slip_cnt  <= 8'd0;
                        match_cnt <= 8'd0;
                        wait_cnt  <= 8'd0;
                    end
                end

                FAIL: begin
                    if (start) begin
                        state     <= CHECK;
                        align_err <= 1'b0;
                        busy      <= 1'b1;
                        slip_cnt  <= 8'd0;
                        match_cnt <= 8'd0;
                        wait_cnt  <= 8'd0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    locked    <= 1'b0;
                    align_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_bitslip_ctrl.sv
// Testbench for lvds_bitslip_ctrl. The deserializer is modelled as a 1-bit
// word rotation: each bitslip pulse reduces the rotation offset by one.
// Expected bitslip cycles go into a queue when a run starts. They are popped
// whenever the DUT pulses bitslip.
module tb_lvds_bitslip_ctrl;

    localparam logic [9:0] TP = 10'h3E0;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [9:0] data_in;
    logic       bitslip;
    logic       busy;
    logic       locked;
    logic       align_err;
    logic [7:0] slip_cnt;

    lvds_bitslip_ctrl #(
        .DATA_WIDTH   (10),
        .TRAIN_PATTERN(TP),
        .MATCH_COUNT  (16),
        .SLIP_WAIT    (4),
        .MAX_SLIPS    (20)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .data_in  (data_in),
        .bitslip  (bitslip),
        .busy     (busy),
        .locked   (locked),
        .align_err(align_err),
        .slip_cnt (slip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run state shared by the tasks below.
    int cyc;
    int prev_pulse;
    int off;
    bit use_model;
    int brk;
    int excl_bad;
    int consec_bad;
    int exp_q[$];

    typedef struct {
        int         off;
        bit         model;
        logic [9:0] raw;
        int         nslips;
        bit         lock;
        int         done;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
        logic [9:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    function automatic logic [11:0] outs();
        return {bitslip, busy, locked, align_err, slip_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle, then sample at the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bitslip) begin
            if (prev_pulse == cyc - 1) consec_bad++;
            prev_pulse = cyc;
            if (exp_q.size() == 0) check("unexpected_bitslip", 32'(cyc), 32'hFFFF_FFFF);
            else                   check("bitslip_cycle", 32'(cyc), 32'(exp_q.pop_front()));
            if (use_model) begin
                off     = (off + 9) % 10;
                data_in = rotl(TP, off);
            end
        end
        if (32'(busy) + 32'(locked) + 32'(align_err) > 32'd1) excl_bad++;
        if (brk >= 0 && cyc == brk)          data_in = 10'h3E1;
        else if (brk >= 0 && cyc == brk + 1) data_in = TP;
    endtask

    // Pulse start, then run until the DUT reports lock or error, within a bounded number of cycles.
    task automatic run_training(input string name, input int off0, input bit model,
                                input logic [9:0] raw, input int brk_at, input int first_mm,
                                input int nslips, input bit exp_lock, input int exp_done);
        exp_q.delete();
        for (int j = 0; j < nslips; j++) exp_q.push_back(first_mm + 6 * j);
        off        = off0;
        use_model  = model;
        brk        = brk_at;
        data_in    = model ? rotl(TP, off0) : raw;
        prev_pulse = -10;
        excl_bad   = 0;
        consec_bad = 0;
        start      = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_at_start"}, 32'(busy), 32'd1);
        check({name, "_flags_at_start"}, 32'({locked, align_err}), 32'd0);
        check({name, "_slipcnt_at_start"}, 32'(slip_cnt), 32'd0);
        while (!locked && !align_err && cyc < 400) step();
        check({name, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        check({name, "_locked"}, 32'(locked), 32'(exp_lock));
        check({name, "_align_err"}, 32'(align_err), 32'(!exp_lock));
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_slip_cnt"}, 32'(slip_cnt), 32'(nslips));
        check({name, "_missing_pulses"}, 32'(exp_q.size()), 32'd0);
        check({name, "_exclusive"}, 32'(excl_bad), 32'd0);
        check({name, "_consecutive"}, 32'(consec_bad), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // offset, model, raw, slips, lock, completion cycle after the start edge
        vecs[0] = '{0, 1'b1, 10'h000, 0,  1'b1, 16};
        vecs[1] = '{3, 1'b1, 10'h000, 3,  1'b1, 34};
        vecs[2] = '{7, 1'b1, 10'h000, 7,  1'b1, 58};
        vecs[3] = '{0, 1'b0, 10'h000, 20, 1'b0, 121};
        vecs[4] = '{9, 1'b1, 10'h000, 9,  1'b1, 70};

        reset_n   = 1'b0;
        start     = 1'b0;
        data_in   = 10'h155;
        use_model = 1'b0;
        brk       = -1;
        off       = 0;
        cyc       = 0;

        // Reset held with the clock running.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in = 10'($urandom);
            check($sformatf("reset_outs_%0d", i), 32'(outs()), 32'd0);
        end
        reset_n = 1'b1;
        data_in = TP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_outs_%0d", i), 32'(outs()), 32'd0);
        end

        // Training runs from the table. Rows 3 and 4 also restart out of FAIL.
        for (int i = 0; i < 5; i++) begin
            run_training($sformatf("vec%0d", i), vecs[i].off, vecs[i].model, vecs[i].raw,
                         -1, 1, vecs[i].nslips, vecs[i].lock, vecs[i].done);
        end

        // Run broken after 15 matches: one slip, then 16 fresh matches.
        run_training("broken_run", 0, 1'b0, TP, 15, 16, 1, 1'b1, 37);

        // Reset asserted during WAIT after two slips.
        exp_q.delete();
        exp_q.push_back(1);
        exp_q.push_back(7);
        off        = 5;
        use_model  = 1'b1;
        brk        = -1;
        prev_pulse = -10;
        data_in    = rotl(TP, 5);
        start      = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("midrun_slip_cnt", 32'(slip_cnt), 32'd2);
        check("midrun_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        check("reset_hold_outs", 32'(outs()), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(outs()), 32'd0);
        run_training("relock", 0, 1'b1, 10'h000, -1, 1, 0, 1'b1, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_bitslip_ctrl.md
# lvds_bitslip_ctrl

Word-alignment controller for one LVDS deserializer lane. It runs in the divided-clock (parallel) domain and compares each deserialized word against a known training pattern. While the lane is misaligned it pulses the deserializer's `bitslip` input, one pulse at a time, with a settle interval after each pulse. It declares lock after a run of consecutive matches, or flags an error if too many slips occur without lock.

## Interface

Parameters:
- `DATA_WIDTH`, 10: deserialized word width; legal values are 2 to 8, 10 and 14.
- `TRAIN_PATTERN`, 10'h3E0: expected training word; `DATA_WIDTH` bits wide.
- `MATCH_COUNT`, 16: consecutive matching words required for lock; range 1 to 255.
- `SLIP_WAIT`, 4: settle cycles after each bitslip pulse, during which input is ignored; range 1 to 255.
- `MAX_SLIPS`, 20: maximum slips before failure; range 1 to 255.

Ports:
- `clk`, input, 1: divided (parallel-word) clock, the same clock that drives the deserializer CLKDIV; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle request to begin or restart training.
- `data_in`, input, DATA_WIDTH: deserialized word, valid every cycle.
- `bitslip`, output, 1: one-cycle slip pulse to the deserializer.
- `busy`, output, 1: training is in progress.
- `locked`, output, 1: alignment has been achieved.
- `align_err`, output, 1: training failed.
- `slip_cnt`, output, 8: number of slips issued in the current training run.

## Operation

- FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL. Every output is a registered function of the state and counter flops.
- Reset (asynchronous, `reset_n`=0):
  - State goes to IDLE.
  - All outputs go to 0.
  - `match_cnt`, `wait_cnt` and `slip_cnt` are cleared.
- IDLE:
  - `start`=1 → go to CHECK.
  - On entry to CHECK, `slip_cnt` and `match_cnt` are cleared.
- CHECK:
  - `busy`=1.
  - `data_in`==`TRAIN_PATTERN`:
    - `match_cnt` increments.
    - If this is match number `MATCH_COUNT` → go to LOCKED.
  - Mismatch:
    - `match_cnt` is cleared.
    - If `slip_cnt`==`MAX_SLIPS` → go to FAIL.
    - Otherwise → go to SLIP.
- SLIP:
  - `bitslip`=1 for exactly this one cycle.
  - `slip_cnt` increments, saturating at 255.
  - Next state is WAIT with `wait_cnt` cleared.
- WAIT:
  - `data_in` is ignored.
  - After `SLIP_WAIT` cycles in WAIT → go to CHECK with `match_cnt`=0.
- LOCKED:
  - `locked`=1, `busy`=0.
  - `slip_cnt` holds its final value.
  - The state is held until `start`=1, which clears `locked`, clears the counters and goes to CHECK.
- FAIL:
  - `align_err`=1, `busy`=0, `locked`=0.
  - The state is held until `start`=1, which clears `align_err`, clears the counters and goes to CHECK.
- `start` in CHECK, SLIP or WAIT is ignored; a training run cannot be retriggered.
- After lock there is no loss-of-lock detection; `data_in` is not monitored. Relock requires `start`.
- `bitslip` is never high in two consecutive cycles. Consecutive pulses are at least `SLIP_WAIT`+2 cycles apart.

## Timing

- A `start` sampled at edge N puts the FSM in CHECK from edge N; `busy`=1 in the cycle following edge N.
- Aligned-from-start case: the first CHECK sample is at edge N+1.
  - `locked` rises after edge N+`MATCH_COUNT`.
  - `busy` falls on that same edge.
- Each slip costs exactly 1 (SLIP) + `SLIP_WAIT` (WAIT) + 1 (mismatching CHECK) cycles.
- Worst case to FAIL: `MAX_SLIPS` × (`SLIP_WAIT`+2) + 1 cycles after CHECK entry.
- At most one of `locked`, `align_err`, `busy` is 1 in any cycle.
- `reset_n` deasserted asynchronously takes effect at the first rising edge after release; reset assertion forces outputs to 0 immediately, with no clock needed.

## Test plan

Bench setup: `DATA_WIDTH`=10, `TRAIN_PATTERN`=10'h3E0, `MATCH_COUNT`=16, `SLIP_WAIT`=4, `MAX_SLIPS`=20. The bench models the deserializer as a 1-bit word rotation applied on each `bitslip` pulse.

- **Reset:** hold `reset_n`=0 with clocks running → `bitslip`, `busy`, `locked`, `align_err` = 0 and `slip_cnt` = 0; no outputs change until `start`.
- **Already aligned:** `data_in`=10'h3E0 constant, `start` pulse at edge N → `locked`=1 after edge N+16, `slip_cnt`=0, `bitslip` never asserted.
- **Offset of 3 bits:** initial rotation offset 3 → exactly 3 `bitslip` pulses, each 6 cycles apart; then `locked`=1 with `slip_cnt`=3.
- **Pattern absent:** `data_in`=10'h000 constant → 20 pulses, then `align_err`=1, `locked`=0, `busy`=0, `slip_cnt`=20; a subsequent `start` clears `align_err` and re-enters CHECK.
- **Run broken before lock:** 15 matches, then one word of 10'h3E1 → `match_cnt` cleared and exactly one `bitslip` issued; with the pattern restored, 16 fresh matches are required before `locked`=1.
- **Reset mid-run:** assert `reset_n`=0 during WAIT after 2 slips → all outputs 0 immediately; after release, a `start` with aligned data locks with `slip_cnt`=0.
